// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared types and defaults for the multi-cycle core sequencer:
//               state encoding, reset constants, handshake channel structs.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  // Architectural reset values
  localparam logic [31:0] PC_RESET = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0

  // Sequencer states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    FETCH_REQ  = 3'd0,
    FETCH_WAIT = 3'd1,
    EXEC       = 3'd2,
    MEM_REQ    = 3'd3,
    MEM_WAIT   = 3'd4,
    WB         = 3'd5,
    HALT       = 3'd6
  } core_mc_state_t;

  // Instruction-fetch request channel
  typedef struct packed {
    logic valid;
    logic ready;
  } if_req_t;

  // Data-memory request channel
  typedef struct packed {
    logic valid;
    logic ready;
    logic wen;
  } dm_req_t;

  // States in which the core is blocked on a memory handshake
  function automatic logic is_hs_state(core_mc_state_t s);
    return (s == FETCH_REQ) || (s == FETCH_WAIT) ||
           (s == MEM_REQ)   || (s == MEM_WAIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hs_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : hs_watchdog
// Description : Handshake watchdog. Counts enabled cycles since the last
//               clear and flags expiry on the TIMEOUT-th enabled cycle.
//               TIMEOUT = 0 disables expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_watchdog #(
  parameter int TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  // Counter never needs to hold more than TIMEOUT-1
  localparam int            CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] c_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [CW-1:0] r_cnt;

  // Wait-cycle counter, cleared whenever the owner changes state
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire = (TIMEOUT > 0) && i_en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/core_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : core_mc_ctrl
// Description : Multi-cycle core sequencer. Owns PC and instruction register,
//               drives handshaked fetch and data ports, and gates regfile
//               writes to exactly one per retired instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module core_mc_ctrl #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] PC_RESET = core_pkg::PC_RESET,
  parameter int          TIMEOUT  = 0,
  parameter int          CNT_W    = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             if_req_valid_o,
  input  logic             if_req_ready_i,
  output logic [XLEN-1:0]  if_addr_o,
  input  logic             if_rsp_valid_i,
  input  logic [31:0]      if_rsp_data_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [31:0]      inst_o,
  input  logic             is_load_i,
  input  logic             is_store_i,
  input  logic             wen_reg_i,
  input  logic             is_halt_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  output logic             dm_req_valid_o,
  input  logic             dm_req_ready_i,
  output logic             dm_wen_o,
  input  logic             dm_rsp_valid_i,
  output logic             reg_wen_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] instret_o,
  output logic             halt_o,
  output logic             err_o
);
  import core_pkg::*;

  core_mc_state_t  r_state, w_next;
  if_req_t         w_if;
  dm_req_t         w_dm;
  logic [XLEN-1:0] r_pc, w_next_pc;
  logic [31:0]     r_inst;
  logic [CNT_W-1:0] r_instret;
  logic            r_err, r_is_store, r_wen;
  logic            w_expire, w_misalign, w_retire, w_timeout;

  assign w_if.valid  = (r_state == FETCH_REQ);
  assign w_if.ready  = if_req_ready_i;
  assign w_dm.valid  = (r_state == MEM_REQ);
  assign w_dm.ready  = dm_req_ready_i;
  assign w_dm.wen    = r_is_store;

  assign w_next_pc  = redirect_i ? redirect_pc_i : (r_pc + XLEN'(4));
  assign w_misalign = |w_next_pc[1:0];
  assign w_retire   = (r_state == WB) || ((r_state == EXEC) && is_halt_i);
  // In a handshake state the only route to HALT is watchdog expiry
  assign w_timeout  = is_hs_state(r_state) && (w_next == HALT);

  hs_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk_i),
    .rst      (rst_i),
    .i_clr    (w_next != r_state),
    .i_en     (is_hs_state(r_state)),
    .o_expire (w_expire)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= FETCH_REQ;
    else       r_state <= w_next;
  end

  // Next-state logic; a completing handshake takes priority over expiry
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH_REQ:  if (if_req_ready_i)      w_next = FETCH_WAIT;
                  else if (w_expire)       w_next = HALT;
      FETCH_WAIT: if (if_rsp_valid_i)      w_next = EXEC;
                  else if (w_expire)       w_next = HALT;
      EXEC:       if (is_halt_i)           w_next = HALT;
                  else if (is_load_i || is_store_i) w_next = MEM_REQ;
                  else                     w_next = WB;
      MEM_REQ:    if (dm_req_ready_i)      w_next = MEM_WAIT;
                  else if (w_expire)       w_next = HALT;
      MEM_WAIT:   if (dm_rsp_valid_i)      w_next = WB;
                  else if (w_expire)       w_next = HALT;
      WB:         w_next = w_misalign ? HALT : FETCH_REQ;
      HALT:       w_next = HALT;
      default:    w_next = FETCH_REQ;
    endcase
  end

  // Output decode from state; every strobe and flag is held low during reset
  always_comb begin
    if_req_valid_o = 1'b0;
    dm_req_valid_o = 1'b0;
    dm_wen_o       = 1'b0;
    reg_wen_o      = 1'b0;
    retire_o       = 1'b0;
    halt_o         = 1'b0;
    if (!rst_i) begin
      if_req_valid_o = w_if.valid;
      dm_req_valid_o = w_dm.valid;
      dm_wen_o       = w_dm.valid && w_dm.wen;
      reg_wen_o      = (r_state == WB) && r_wen;
      retire_o       = w_retire;
      halt_o         = (r_state == HALT);
    end
  end

  // PC, instruction register, latched decode flags, retire counter, error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc       <= XLEN'(PC_RESET);
      r_inst     <= NOP_INST;
      r_instret  <= '0;
      r_err      <= 1'b0;
      r_is_store <= 1'b0;
      r_wen      <= 1'b0;
    end else begin
      if ((r_state == FETCH_WAIT) && if_rsp_valid_i) r_inst <= if_rsp_data_i;
      if (r_state == EXEC) begin
        r_is_store <= is_store_i;
        r_wen      <= wen_reg_i && !is_store_i;
      end
      if ((r_state == WB) && !w_misalign) r_pc <= w_next_pc;
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
      if (w_timeout || ((r_state == WB) && w_misalign)) r_err <= 1'b1;
    end
  end

  assign if_addr_o = r_pc;
  assign pc_o      = r_pc;
  assign inst_o    = r_inst;
  assign instret_o = r_instret;
  assign err_o     = r_err && !rst_i;

endmodule
`default_nettype wire

// File: tb/tb_core_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_mc_ctrl
// Description : Directed, table-driven bench for core_mc_ctrl plus hand
//               sequences for backpressure, store/misalign, halt and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_addr, if_rsp_data, pc, inst, redirect_pc;
  logic        is_load, is_store, wen_reg, is_halt, redirect;
  logic        dm_req_valid, dm_req_ready, dm_wen, dm_rsp_valid;
  logic        reg_wen, retire, halt, err;
  logic [63:0] instret;

  int n_chk  = 0;
  int n_fail = 0;
  int n_ret  = 0;

  always #5 clk = ~clk;

  core_mc_ctrl #(
    .XLEN(32), .PC_RESET(32'h8000_0000), .TIMEOUT(8), .CNT_W(64)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_valid_o(if_req_valid), .if_req_ready_i(if_req_ready),
    .if_addr_o(if_addr), .if_rsp_valid_i(if_rsp_valid), .if_rsp_data_i(if_rsp_data),
    .pc_o(pc), .inst_o(inst),
    .is_load_i(is_load), .is_store_i(is_store), .wen_reg_i(wen_reg), .is_halt_i(is_halt),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .dm_req_valid_o(dm_req_valid), .dm_req_ready_i(dm_req_ready), .dm_wen_o(dm_wen),
    .dm_rsp_valid_i(dm_rsp_valid),
    .reg_wen_o(reg_wen), .retire_o(retire), .instret_o(instret),
    .halt_o(halt), .err_o(err)
  );

  typedef struct {
    logic        rdy, rsp;
    logic [31:0] data;
    logic        ld, st, wen, rd;
    logic [31:0] rpc;
    logic        dmr, dmrsp;
    logic        e_ifv;
    logic [31:0] e_pc, e_inst;
    logic        e_dmv, e_dmw, e_rw, e_ret;
    logic [63:0] e_cnt;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_ready = 0; if_rsp_valid = 0; if_rsp_data = 32'h0;
    is_load = 0; is_store = 0; wen_reg = 0; is_halt = 0;
    redirect = 0; redirect_pc = 32'h0; dm_req_ready = 0; dm_rsp_valid = 0;
  endtask

  // Two reset cycles, reset-state checks while rst is still high, then release
  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    chk("rst pc", pc, 32'h8000_0000);
    chk("rst inst", inst, 32'h13);
    chk("rst instret", instret, 0);
    chk("rst valids", {if_req_valid, dm_req_valid, dm_wen, reg_wen, retire, halt, err}, 0);
    rst = 0;
  endtask

  initial begin
    // rdy rsp data ld st wen rd rpc dmr dmrsp | ifv pc inst dmv dmw rw ret cnt
    tbl[0]  = '{1,0,32'h0,       0,0,0,0,32'h0,         0,0, 1,32'h8000_0000,32'h13,      0,0,0,0,0};
    tbl[1]  = '{0,1,32'h0010_0093,0,0,0,0,32'h0,        0,0, 0,32'h8000_0000,32'h13,      0,0,0,0,0};
    tbl[2]  = '{0,0,32'h0,       0,0,1,0,32'h0,         0,0, 0,32'h8000_0000,32'h0010_0093,0,0,0,0,0};
    tbl[3]  = '{0,0,32'h0,       0,0,1,0,32'h0,         0,0, 0,32'h8000_0000,32'h0010_0093,0,0,1,1,0};
    tbl[4]  = '{1,0,32'h0,       0,0,0,0,32'h0,         0,0, 1,32'h8000_0004,32'h0010_0093,0,0,0,0,1};
    tbl[5]  = '{0,1,32'h0000_2103,0,0,0,0,32'h0,        0,0, 0,32'h8000_0004,32'h0010_0093,0,0,0,0,1};
    tbl[6]  = '{0,0,32'h0,       1,0,1,0,32'h0,         0,0, 0,32'h8000_0004,32'h0000_2103,0,0,0,0,1};
    tbl[7]  = '{0,0,32'h0,       1,0,1,0,32'h0,         1,0, 0,32'h8000_0004,32'h0000_2103,1,0,0,0,1};
    tbl[8]  = '{0,0,32'h0,       1,0,1,0,32'h0,         0,0, 0,32'h8000_0004,32'h0000_2103,0,0,0,0,1};
    tbl[9]  = '{0,0,32'h0,       1,0,1,0,32'h0,         0,1, 0,32'h8000_0004,32'h0000_2103,0,0,0,0,1};
    tbl[10] = '{0,0,32'h0,       1,0,1,0,32'h0,         0,0, 0,32'h8000_0004,32'h0000_2103,0,0,1,1,1};
    tbl[11] = '{1,0,32'h0,       0,0,0,0,32'h0,         0,0, 1,32'h8000_0008,32'h0000_2103,0,0,0,0,2};
    tbl[12] = '{0,1,32'h0000_0063,0,0,0,0,32'h0,        0,0, 0,32'h8000_0008,32'h0000_2103,0,0,0,0,2};
    tbl[13] = '{0,0,32'h0,       0,0,0,1,32'h8000_0100, 0,0, 0,32'h8000_0008,32'h0000_0063,0,0,0,0,2};
    tbl[14] = '{0,0,32'h0,       0,0,0,1,32'h8000_0100, 0,0, 0,32'h8000_0008,32'h0000_0063,0,0,0,1,2};
    tbl[15] = '{0,0,32'h0,       0,0,0,0,32'h0,         0,0, 1,32'h8000_0100,32'h0000_0063,0,0,0,0,3};

    do_reset();

    // ALU, load and taken branch, one cycle per row
    for (int i = 0; i < 16; i++) begin
      if_req_ready = tbl[i].rdy;  if_rsp_valid = tbl[i].rsp; if_rsp_data = tbl[i].data;
      is_load = tbl[i].ld; is_store = tbl[i].st; wen_reg = tbl[i].wen;
      redirect = tbl[i].rd; redirect_pc = tbl[i].rpc;
      dm_req_ready = tbl[i].dmr; dm_rsp_valid = tbl[i].dmrsp;
      #1;
      chk($sformatf("row%0d if_valid", i), if_req_valid, tbl[i].e_ifv);
      chk($sformatf("row%0d if_addr", i), if_addr, tbl[i].e_pc);
      chk($sformatf("row%0d pc", i), pc, tbl[i].e_pc);
      chk($sformatf("row%0d inst", i), inst, tbl[i].e_inst);
      chk($sformatf("row%0d dm_valid", i), dm_req_valid, tbl[i].e_dmv);
      chk($sformatf("row%0d dm_wen", i), dm_wen, tbl[i].e_dmw);
      chk($sformatf("row%0d reg_wen", i), reg_wen, tbl[i].e_rw);
      chk($sformatf("row%0d retire", i), retire, tbl[i].e_ret);
      chk($sformatf("row%0d instret", i), instret, tbl[i].e_cnt);
      chk($sformatf("row%0d halt_err", i), {halt, err}, 0);
      step();
    end

    // Fetch backpressure: ready low 5 cycles total, stray response data ignored
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      if_rsp_valid = 1; if_rsp_data = 32'hDEAD_BEEF;
      #1;
      chk("bp valid held", if_req_valid, 1);
      chk("bp addr stable", if_addr, 32'h8000_0100);
      step();
    end
    if_req_ready = 1; if_rsp_valid = 1; if_rsp_data = 32'hDEAD_BEEF;
    #1;
    chk("bp accept addr", if_addr, 32'h8000_0100);
    step();
    if_req_ready = 0; if_rsp_valid = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("bp wait inst", inst, 32'h0000_0063);
      chk("bp wait valid", if_req_valid, 0);
      step();
    end
    if_rsp_valid = 1; if_rsp_data = 32'h0011_2023;
    #1;
    chk("bp rsp beat inst", inst, 32'h0000_0063);
    step();
    idle_inputs();

    // Store, then redirect to a misaligned target
    is_store = 1; wen_reg = 1;
    #1;
    chk("st latched inst", inst, 32'h0011_2023);
    chk("st exec reg_wen", reg_wen, 0);
    step();
    #1;
    chk("st req dm", {dm_req_valid, dm_wen}, 2'b11);
    step();
    dm_req_ready = 1;
    #1;
    chk("st accept dm", {dm_req_valid, dm_wen}, 2'b11);
    step();
    dm_req_ready = 0; dm_rsp_valid = 1;
    #1;
    chk("st wait dm_valid", dm_req_valid, 0);
    chk("st wait reg_wen", reg_wen, 0);
    step();
    dm_rsp_valid = 0; redirect = 1; redirect_pc = 32'h8000_0102;
    #1;
    chk("st wb reg_wen", reg_wen, 0);
    chk("st wb retire", retire, 1);
    chk("st wb err", err, 0);
    step();
    chk("mis err_halt", {err, halt}, 2'b11);
    chk("mis pc kept", pc, 32'h8000_0100);
    chk("mis instret", instret, 4);
    if_req_ready = 1; dm_req_ready = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("mis no requests", {if_req_valid, dm_req_valid, reg_wen}, 0);
      step();
    end

    // Handshake on the expiry cycle wins, then halt instruction
    do_reset();
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("tw err low", err, 0);
      step();
    end
    if_req_ready = 1;
    #1;
    chk("tw expiry-cycle accept", if_req_valid, 1);
    step();
    if_req_ready = 0;
    chk("tw no err", {err, halt, if_req_valid}, 0);
    if_rsp_valid = 1; if_rsp_data = 32'h0010_0073;
    step();
    if_rsp_valid = 0; is_halt = 1;
    #1;
    chk("halt exec retire", retire, 1);
    if (retire === 1'b1) n_ret++;
    step();
    if_req_ready = 1; if_rsp_valid = 1; dm_req_ready = 1;
    for (int k = 0; k < 20; k++) begin
      chk("halt hold", {halt, err, if_req_valid, dm_req_valid, reg_wen}, 5'b10000);
      chk("halt pc_inst", {pc, inst}, {32'h8000_0000, 32'h0010_0073});
      if (retire === 1'b1) n_ret++;
      step();
    end
    chk("halt retire once", n_ret, 1);

    // Fetch ready stuck low: error after 8 cycles
    do_reset();
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("to before expiry", {err, if_req_valid}, 2'b01);
      step();
    end
    chk("to after expiry", {err, halt, if_req_valid}, 3'b110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
